// File: rtl/regfile_sb_pkg.sv
// Shared constants and helpers for the architectural register file slice.
// NUM_REGS/DATA_W/IDX_W/CNT_W fix the geometry; ZERO_REG is the hardwired-zero index.
package regfile_sb_pkg;

    localparam int NUM_REGS = 32;
    localparam int DATA_W   = 32;
    localparam int IDX_W    = 5;
    localparam int CNT_W    = 6;

    localparam logic [IDX_W-1:0] ZERO_REG = '0;

    // Apply one cycle of pending-count movement: inc on a 0->1 pend edge,
    // dec on a 1->0 pend edge; both together (different registers) cancel.
    function automatic logic [CNT_W-1:0] count_step(input logic [CNT_W-1:0] cnt,
                                                    input logic             inc,
                                                    input logic             dec);
        logic [CNT_W-1:0] res;
        case ({inc, dec})
            2'b10:   res = cnt + CNT_W'(1);
            2'b01:   res = cnt - CNT_W'(1);
            default: res = cnt;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/mux_32.sv
// 32:1 bus multiplexer feeding one register-file read port.
module mux_32
    import regfile_sb_pkg::*;
(
    input  logic [IDX_W-1:0]  select,
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [DATA_W-1:0] in8,
    input  logic [DATA_W-1:0] in9,
    input  logic [DATA_W-1:0] in10,
    input  logic [DATA_W-1:0] in11,
    input  logic [DATA_W-1:0] in12,
    input  logic [DATA_W-1:0] in13,
    input  logic [DATA_W-1:0] in14,
    input  logic [DATA_W-1:0] in15,
    input  logic [DATA_W-1:0] in16,
    input  logic [DATA_W-1:0] in17,
    input  logic [DATA_W-1:0] in18,
    input  logic [DATA_W-1:0] in19,
    input  logic [DATA_W-1:0] in20,
    input  logic [DATA_W-1:0] in21,
    input  logic [DATA_W-1:0] in22,
    input  logic [DATA_W-1:0] in23,
    input  logic [DATA_W-1:0] in24,
    input  logic [DATA_W-1:0] in25,
    input  logic [DATA_W-1:0] in26,
    input  logic [DATA_W-1:0] in27,
    input  logic [DATA_W-1:0] in28,
    input  logic [DATA_W-1:0] in29,
    input  logic [DATA_W-1:0] in30,
    input  logic [DATA_W-1:0] in31,
    output logic [DATA_W-1:0] out
);

    logic [DATA_W-1:0] bus [NUM_REGS];

    assign bus = '{in0,  in1,  in2,  in3,  in4,  in5,  in6,  in7,
                   in8,  in9,  in10, in11, in12, in13, in14, in15,
                   in16, in17, in18, in19, in20, in21, in22, in23,
                   in24, in25, in26, in27, in28, in29, in30, in31};

    assign out = bus[select];

endmodule

// File: rtl/register_32.sv
// 32-bit storage flop with write enable and asynchronous active-high clear.
module register_32
    import regfile_sb_pkg::*;
(
    input  logic              clock,
    input  logic              clr,
    input  logic              we,
    input  logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] q
);

    // Hold the register value; clear wins immediately, otherwise load on enable.
    always_ff @(posedge clock or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/regfile_sb.sv
// Architectural register file (32 x 32) with two combinational read ports,
// one synchronous write port and a per-register pending scoreboard for
// in-flight multdiv destinations.
// Optional feature macro: REGFILE_BYPASS_EN enables write-through forwarding
// of the write port (data and post-edge pend bit) onto the read ports.
module regfile_sb
    import regfile_sb_pkg::*;
(
    input  logic              clock,
    input  logic              ctrl_reset,
    input  logic              ctrl_writeEnable,
    input  logic [IDX_W-1:0]  ctrl_writeReg,
    input  logic [DATA_W-1:0] data_writeReg,
    input  logic [IDX_W-1:0]  ctrl_readRegA,
    input  logic [IDX_W-1:0]  ctrl_readRegB,
    output logic [DATA_W-1:0] data_readRegA,
    output logic [DATA_W-1:0] data_readRegB,
    input  logic              ctrl_pendSet,
    input  logic [IDX_W-1:0]  ctrl_pendReg,
    output logic              pend_A,
    output logic              pend_B,
    output logic [CNT_W-1:0]  pend_count
);

    logic [DATA_W-1:0]   regs [NUM_REGS];
    logic [DATA_W-1:0]   mux_a;
    logic [DATA_W-1:0]   mux_b;
    logic [NUM_REGS-1:0] pend;
    logic [NUM_REGS-1:0] pend_nxt;
    logic [CNT_W-1:0]    cnt_q;
    logic                wr_hit;
    logic                ps_hit;
    logic                cnt_inc;
    logic                cnt_dec;

    // Register 0 has no storage; it always reads as zero.
    assign regs[0] = '0;

    assign wr_hit = ctrl_writeEnable && (ctrl_writeReg != ZERO_REG);
    assign ps_hit = ctrl_pendSet && (ctrl_pendReg != ZERO_REG);

    for (genvar i = 1; i < NUM_REGS; i++) begin : g_reg
        logic we_i;
        assign we_i = ctrl_writeEnable && (ctrl_writeReg == IDX_W'(i));
        register_32 u_reg (
            .clock (clock),
            .clr   (ctrl_reset),
            .we    (we_i),
            .d     (data_writeReg),
            .q     (regs[i])
        );
    end

    mux_32 u_mux_a (
        .select (ctrl_readRegA),
        .in0  (regs[0]),  .in1  (regs[1]),  .in2  (regs[2]),  .in3  (regs[3]),
        .in4  (regs[4]),  .in5  (regs[5]),  .in6  (regs[6]),  .in7  (regs[7]),
        .in8  (regs[8]),  .in9  (regs[9]),  .in10 (regs[10]), .in11 (regs[11]),
        .in12 (regs[12]), .in13 (regs[13]), .in14 (regs[14]), .in15 (regs[15]),
        .in16 (regs[16]), .in17 (regs[17]), .in18 (regs[18]), .in19 (regs[19]),
        .in20 (regs[20]), .in21 (regs[21]), .in22 (regs[22]), .in23 (regs[23]),
        .in24 (regs[24]), .in25 (regs[25]), .in26 (regs[26]), .in27 (regs[27]),
        .in28 (regs[28]), .in29 (regs[29]), .in30 (regs[30]), .in31 (regs[31]),
        .out    (mux_a)
    );

    mux_32 u_mux_b (
        .select (ctrl_readRegB),
        .in0  (regs[0]),  .in1  (regs[1]),  .in2  (regs[2]),  .in3  (regs[3]),
        .in4  (regs[4]),  .in5  (regs[5]),  .in6  (regs[6]),  .in7  (regs[7]),
        .in8  (regs[8]),  .in9  (regs[9]),  .in10 (regs[10]), .in11 (regs[11]),
        .in12 (regs[12]), .in13 (regs[13]), .in14 (regs[14]), .in15 (regs[15]),
        .in16 (regs[16]), .in17 (regs[17]), .in18 (regs[18]), .in19 (regs[19]),
        .in20 (regs[20]), .in21 (regs[21]), .in22 (regs[22]), .in23 (regs[23]),
        .in24 (regs[24]), .in25 (regs[25]), .in26 (regs[26]), .in27 (regs[27]),
        .in28 (regs[28]), .in29 (regs[29]), .in30 (regs[30]), .in31 (regs[31]),
        .out    (mux_b)
    );

    // Next pend vector and count movement; pendSet is applied after the
    // write-clear so a same-register issue following its completion stays pending.
    always_comb begin
        pend_nxt = pend;
        if (wr_hit) begin
            pend_nxt[ctrl_writeReg] = 1'b0;
        end
        if (ps_hit) begin
            pend_nxt[ctrl_pendReg] = 1'b1;
        end
        pend_nxt[0] = 1'b0;
        cnt_inc = ps_hit && !pend[ctrl_pendReg];
        cnt_dec = wr_hit && pend[ctrl_writeReg]
                  && !(ps_hit && (ctrl_pendReg == ctrl_writeReg));
    end

    // Scoreboard state: pend bits and their population count move on the same edge.
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            pend  <= '0;
            cnt_q <= '0;
        end else begin
            pend  <= pend_nxt;
            cnt_q <= count_step(cnt_q, cnt_inc, cnt_dec);
        end
    end

    assign pend_count = cnt_q;

`ifdef REGFILE_BYPASS_EN
    logic byp_a;
    logic byp_b;

    // Forwarding is suppressed under reset so every output reads zero while it is held.
    assign byp_a = !ctrl_reset && wr_hit && (ctrl_readRegA == ctrl_writeReg);
    assign byp_b = !ctrl_reset && wr_hit && (ctrl_readRegB == ctrl_writeReg);

    assign data_readRegA = byp_a ? data_writeReg : mux_a;
    assign data_readRegB = byp_b ? data_writeReg : mux_b;
    assign pend_A        = !ctrl_reset && pend_nxt[ctrl_readRegA];
    assign pend_B        = !ctrl_reset && pend_nxt[ctrl_readRegB];
`else
    assign data_readRegA = mux_a;
    assign data_readRegB = mux_b;
    assign pend_A        = pend[ctrl_readRegA];
    assign pend_B        = pend[ctrl_readRegB];
`endif

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: directed vector table, hand-written
// corner sequences and randomized traffic against a behavioural model.
module tb_regfile_sb;
    import regfile_sb_pkg::*;

    logic        clock = 1'b0;
    logic        ctrl_reset = 1'b1;
    logic        ctrl_writeEnable = 1'b0;
    logic [4:0]  ctrl_writeReg = '0;
    logic [31:0] data_writeReg = '0;
    logic [4:0]  ctrl_readRegA = '0;
    logic [4:0]  ctrl_readRegB = '0;
    logic [31:0] data_readRegA;
    logic [31:0] data_readRegB;
    logic        ctrl_pendSet = 1'b0;
    logic [4:0]  ctrl_pendReg = '0;
    logic        pend_A;
    logic        pend_B;
    logic [5:0]  pend_count;

    always #5 clock = ~clock;

    regfile_sb dut (
        .clock            (clock),
        .ctrl_reset       (ctrl_reset),
        .ctrl_writeEnable (ctrl_writeEnable),
        .ctrl_writeReg    (ctrl_writeReg),
        .data_writeReg    (data_writeReg),
        .ctrl_readRegA    (ctrl_readRegA),
        .ctrl_readRegB    (ctrl_readRegB),
        .data_readRegA    (data_readRegA),
        .data_readRegB    (data_readRegB),
        .ctrl_pendSet     (ctrl_pendSet),
        .ctrl_pendReg     (ctrl_pendReg),
        .pend_A           (pend_A),
        .pend_B           (pend_B),
        .pend_count       (pend_count)
    );

    int tests = 0;
    int fails = 0;

    // Behavioural model: plain arrays of contents and pending flags.
    logic [31:0] mem    [32];
    bit          pend_m [32];

    typedef struct {
        bit          we;
        logic [4:0]  wr;
        logic [31:0] wd;
        bit          ps;
        logic [4:0]  pr;
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [31:0] ea;
        logic [31:0] eb;
        bit          epa;
        bit          epb;
        logic [5:0]  ecnt;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic int model_cnt();
        int c = 0;
        for (int i = 1; i < 32; i++) if (pend_m[i]) c++;
        return c;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) begin
            mem[i]    = '0;
            pend_m[i] = 1'b0;
        end
    endtask

    task automatic model_step(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                              input bit ps, input logic [4:0] pr);
        if (we && wr != 0) begin
            mem[wr]    = wd;
            pend_m[wr] = 1'b0;
        end
        if (ps && pr != 0) pend_m[pr] = 1'b1;
    endtask

    // Pend flag of idx as it will be after the coming edge.
    function automatic bit post_pend(input logic [4:0] idx);
        if (idx == 0) return 1'b0;
        if (ctrl_pendSet && ctrl_pendReg == idx) return 1'b1;
        if (ctrl_writeEnable && ctrl_writeReg == idx) return 1'b0;
        return pend_m[idx];
    endfunction

    function automatic logic [31:0] exp_read(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        if (ctrl_writeEnable && ctrl_writeReg != 0 && ctrl_writeReg == idx) return data_writeReg;
`endif
        return mem[idx];
    endfunction

    function automatic bit exp_pend(input logic [4:0] idx);
`ifdef REGFILE_BYPASS_EN
        return post_pend(idx);
`else
        return pend_m[idx];
`endif
    endfunction

    task automatic drive(input bit we, input logic [4:0] wr, input logic [31:0] wd,
                         input bit ps, input logic [4:0] pr,
                         input logic [4:0] ra, input logic [4:0] rb);
        ctrl_writeEnable = we;
        ctrl_writeReg    = wr;
        data_writeReg    = wd;
        ctrl_pendSet     = ps;
        ctrl_pendReg     = pr;
        ctrl_readRegA    = ra;
        ctrl_readRegB    = rb;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".rdA"}, data_readRegA, exp_read(ctrl_readRegA));
        chk({tag, ".rdB"}, data_readRegB, exp_read(ctrl_readRegB));
        chk({tag, ".pendA"}, 32'(pend_A), 32'(exp_pend(ctrl_readRegA)));
        chk({tag, ".pendB"}, 32'(pend_B), 32'(exp_pend(ctrl_readRegB)));
        chk({tag, ".cnt"}, 32'(pend_count), 32'(model_cnt()));
    endtask

    // One clock with currently driven inputs; optional pre-edge check, then model update.
    task automatic cyc(input bit do_chk, input string tag);
        #1;
        if (do_chk) check_model(tag);
        @(posedge clock);
        model_step(ctrl_writeEnable, ctrl_writeReg, data_writeReg, ctrl_pendSet, ctrl_pendReg);
        @(negedge clock);
    endtask

    initial begin
        logic [31:0] exp_byp;
        bit          exp_byp_p;

        model_reset();
        tbl[0] = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b0, 5'd0, 5'd5, 5'd0, 32'hDEADBEEF, 32'h0,        1'b0, 1'b0, 6'd0};
        tbl[1] = '{1'b1, 5'd0,  32'h00001234, 1'b0, 5'd0, 5'd0, 5'd5, 32'h0,        32'hDEADBEEF, 1'b0, 1'b0, 6'd0};
        tbl[2] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
        tbl[3] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7, 5'd7, 5'd5, 32'h0,        32'hDEADBEEF, 1'b1, 1'b0, 6'd1};
        tbl[4] = '{1'b1, 5'd7,  32'h00000055, 1'b0, 5'd0, 5'd7, 5'd0, 32'h00000055, 32'h0,        1'b0, 1'b0, 6'd0};
        tbl[5] = '{1'b1, 5'd9,  32'h00000099, 1'b1, 5'd9, 5'd7, 5'd9, 32'h00000055, 32'h00000099, 1'b0, 1'b1, 6'd1};
        tbl[6] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd3, 5'd3, 5'd9, 32'h0,        32'h00000099, 1'b1, 1'b1, 6'd2};
        tbl[7] = '{1'b1, 5'd3,  32'h00000033, 1'b1, 5'd4, 5'd3, 5'd4, 32'h00000033, 32'h0,        1'b0, 1'b1, 6'd2};
        tbl[8] = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd0, 5'd0, 5'd0, 32'h0,        32'h0,        1'b0, 1'b0, 6'd2};
        tbl[9] = '{1'b1, 5'd4,  32'h00000044, 1'b0, 5'd0, 5'd4, 5'd9, 32'h00000044, 32'h00000099, 1'b0, 1'b1, 6'd1};

        // Reset, then sweep every index on both ports.
        @(negedge clock);
        @(negedge clock);
        ctrl_reset = 1'b0;
        for (int i = 0; i < 32; i++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'(i), 5'(31 - i));
            #1;
            chk("rst.rdA", data_readRegA, 32'h0);
            chk("rst.rdB", data_readRegB, 32'h0);
            chk("rst.pendA", 32'(pend_A), 32'h0);
            chk("rst.pendB", 32'(pend_B), 32'h0);
            chk("rst.cnt", 32'(pend_count), 32'h0);
            @(negedge clock);
        end

        // Directed vector table: apply op, then read back the post-edge state.
        for (int i = 0; i < 10; i++) begin
            drive(tbl[i].we, tbl[i].wr, tbl[i].wd, tbl[i].ps, tbl[i].pr, tbl[i].ra, tbl[i].rb);
            cyc(1'b0, "tbl");
            drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, tbl[i].ra, tbl[i].rb);
            #1;
            chk($sformatf("tbl%0d.rdA", i), data_readRegA, tbl[i].ea);
            chk($sformatf("tbl%0d.rdB", i), data_readRegB, tbl[i].eb);
            chk($sformatf("tbl%0d.pendA", i), 32'(pend_A), 32'(tbl[i].epa));
            chk($sformatf("tbl%0d.pendB", i), 32'(pend_B), 32'(tbl[i].epb));
            chk($sformatf("tbl%0d.cnt", i), 32'(pend_count), 32'(tbl[i].ecnt));
        end

        // Mark every register pending; the count saturates at 31 without wrapping.
        for (int r = 1; r < 32; r++) begin
            drive(1'b0, 5'd0, 32'h0, 1'b1, 5'(r), 5'(r), 5'd0);
            cyc(1'b1, "pendall");
        end
        drive(1'b0, 5'd0, 32'h0, 1'b1, 5'd31, 5'd31, 5'd0);
        #1;
        chk("pendall.cnt", 32'(pend_count), 32'd31);
        cyc(1'b1, "repend");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd31, 5'd0);
        #1;
        chk("repend.cnt", 32'(pend_count), 32'd31);

        // Same-cycle read of the register being written.
`ifdef REGFILE_BYPASS_EN
        exp_byp   = 32'hA5A5A5A5;
        exp_byp_p = 1'b0;
`else
        exp_byp   = 32'h0;
        exp_byp_p = 1'b1;
`endif
        drive(1'b1, 5'd12, 32'hA5A5A5A5, 1'b0, 5'd0, 5'd12, 5'd12);
        #1;
        chk("byp.rdA", data_readRegA, exp_byp);
        chk("byp.pendA", 32'(pend_A), 32'(exp_byp_p));
        @(posedge clock);
        model_step(1'b1, 5'd12, 32'hA5A5A5A5, 1'b0, 5'd0);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd9);
        #1;
        chk("postbyp.rdA", data_readRegA, 32'hA5A5A5A5);
        chk("postbyp.pendA", 32'(pend_A), 32'h0);
        chk("postbyp.cnt", 32'(pend_count), 32'd30);

        // Asynchronous reset in the middle of a write + pendSet.
        @(negedge clock);
        drive(1'b1, 5'd12, 32'hFFFF0000, 1'b1, 5'd12, 5'd12, 5'd9);
        #1;
        ctrl_reset = 1'b1;
        #1;
        chk("arst.rdA", data_readRegA, 32'h0);
        chk("arst.rdB", data_readRegB, 32'h0);
        chk("arst.pendA", 32'(pend_A), 32'h0);
        chk("arst.pendB", 32'(pend_B), 32'h0);
        chk("arst.cnt", 32'(pend_count), 32'h0);
        @(negedge clock);
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd9);
        #1;
        chk("arst2.rdA", data_readRegA, 32'h0);
        chk("arst2.cnt", 32'(pend_count), 32'h0);
        ctrl_reset = 1'b0;
        model_reset();
        @(negedge clock);
        drive(1'b1, 5'd12, 32'h00000077, 1'b0, 5'd0, 5'd12, 5'd9);
        cyc(1'b1, "first");
        drive(1'b0, 5'd0, 32'h0, 1'b0, 5'd0, 5'd12, 5'd9);
        #1;
        chk("first.rdA", data_readRegA, 32'h00000077);

        // Randomized traffic against the model, biased toward index collisions.
        for (int n = 0; n < 400; n++) begin
            logic [4:0] wr;
            logic [4:0] pr;
            logic [4:0] ra;
            logic [4:0] rb;
            bit         narrow;
            narrow = ($urandom_range(0, 1) == 1);
            wr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            pr = narrow ? 5'($urandom_range(0, 7)) : 5'($urandom_range(0, 31));
            ra = ($urandom_range(0, 3) == 0) ? wr : 5'($urandom_range(0, 31));
            rb = ($urandom_range(0, 3) == 0) ? pr : 5'($urandom_range(0, 31));
            drive(($urandom_range(0, 2) != 0), wr, $urandom, ($urandom_range(0, 2) == 0), pr, ra, rb);
            cyc(1'b1, "rand");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
